alu_op_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of the shared 8-bit ALU operation unit (NAND, AND, OR and so on).
- Accepts an operation request, drives the unit's operands and a start pulse, then waits for the unit's done.
- Returns the result to the requester, tagged with its ID.
- A watchdog ends any operation whose done never arrives, so the datapath cannot hang.

---
 rtl/alu_op_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_op_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing one 8-bit ALU operation unit.
// Issues a start pulse, waits for done (guarded by a watchdog), and returns the tagged result.
module alu_op_arbiter #(
  parameter int WIDTH   = 8,
  parameter int OPW     = 3,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             alu_start,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_sum,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_last_grant;
  logic [7:0]       r_cnt;
  logic [OPW-1:0]   r_alu_op;
  logic [WIDTH-1:0] r_alu_x;
  logic [WIDTH-1:0] r_alu_y;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_err;

  logic w_grant0;
  logic w_grant1;
  logic w_accept;
  logic w_timeout;

  // Under contention the requester that did not win last time gets the grant.
  assign w_grant0  = req0_valid && (!req1_valid || r_last_grant);
  assign w_grant1  = req1_valid && (!req0_valid || !r_last_grant);
  assign w_accept  = (r_state == S_IDLE) && (w_grant0 || w_grant1);
  assign w_timeout = (r_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (alu_done || w_timeout) w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (r_state == S_IDLE) && w_grant0;
    req1_ready = (r_state == S_IDLE) && w_grant1;
    alu_start  = (r_state == S_ISSUE);
    rsp_valid  = (r_state == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_alu_op     <= '0;
      r_alu_x      <= '0;
      r_alu_y      <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_alu_op     <= w_grant0 ? req0_op : req1_op;
            r_alu_x      <= w_grant0 ? req0_a  : req1_a;
            r_alu_y      <= w_grant0 ? req0_b  : req1_b;
            r_rsp_id     <= w_grant1;
            r_last_grant <= w_grant1;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          // done takes priority over a coincident watchdog expiry
          if (alu_done) begin
            r_rsp_data <= alu_sum;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_op   = r_alu_op;
  assign alu_x    = r_alu_x;
  assign alu_y    = r_alu_y;
  assign rsp_id   = r_rsp_id;
  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Randomized self-checking bench for alu_op_arbiter with a transaction-level reference model
// and a behavioural ALU unit that answers after a chosen number of WAIT cycles (or never).
module tb_alu_op_arbiter;

  localparam int W  = 8;
  localparam int OW = 3;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [OW-1:0] req0_op = '0, req1_op = '0;
  logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          alu_start;
  logic [OW-1:0] alu_op;
  logic [W-1:0]  alu_x, alu_y;
  logic          alu_done = 1'b0;
  logic [W-1:0]  alu_sum = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_id;
  logic [W-1:0]  rsp_data;
  logic          rsp_err;

  int n_vec = 0;
  int n_err = 0;
  int last_grant = 1;

  alu_op_arbiter #(.WIDTH(W), .OPW(OW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_start(alu_start), .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y),
    .alu_done(alu_done), .alu_sum(alu_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bench-side ALU unit; opcode 0 is NAND.
  function automatic logic [W-1:0] alu_ref(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0: return ~(a & b);
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return a ^ b;
      3'd4: return ~(a | b);
      3'd5: return a + b;
      3'd6: return a - b;
      default: return ~a;
    endcase
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"}, alu_start, 0);
    chk({tag, "_op"},    alu_op, 0);
    chk({tag, "_x"},     alu_x, 0);
    chk({tag, "_y"},     alu_y, 0);
    chk({tag, "_rv"},    rsp_valid, 0);
    chk({tag, "_rid"},   rsp_id, 0);
    chk({tag, "_rdata"}, rsp_data, 0);
    chk({tag, "_rerr"},  rsp_err, 0);
    chk({tag, "_rdy"},   {req0_ready, req1_ready}, 0);
  endtask

  // Entered and left at a negedge with the DUT idle. lat: WAIT cycle on which done
  // is returned (0 or > TO means the unit never answers). stall: cycles rsp_ready is held low.
  task automatic run_txn(input bit v0, input bit v1,
                         input logic [OW-1:0] o0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [OW-1:0] o1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input int lat, input bit issue_done, input int stall);
    int win, wend;
    logic [OW-1:0] eop;
    logic [W-1:0] ex, ey, eres, edata;
    bit eerr;
    win = (v0 && v1) ? (last_grant == 1 ? 0 : 1) : (v0 ? 0 : 1);
    eop = win == 0 ? o0 : o1;
    ex  = win == 0 ? a0 : a1;
    ey  = win == 0 ? b0 : b1;
    eres = alu_ref(eop, ex, ey);
    if (lat >= 1 && lat <= TO) begin
      wend = lat; edata = eres; eerr = 1'b0;
    end else begin
      wend = TO; edata = '0; eerr = 1'b1;
    end

    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    rsp_ready = 1'b0; alu_done = 1'b0;
    #1;
    chk("idle_rdy0", req0_ready, win == 0);
    chk("idle_rdy1", req1_ready, win == 1);
    @(posedge clk);
    last_grant = win;

    @(negedge clk);
    chk("issue_start", alu_start, 1);
    chk("issue_op", alu_op, eop);
    chk("issue_x", alu_x, ex);
    chk("issue_y", alu_y, ey);
    chk("issue_rdy", {req0_ready, req1_ready}, 0);
    alu_done = issue_done;
    alu_sum  = 8'($urandom);

    for (int k = 1; k <= wend; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("wait_start", alu_start, 0);
      chk("wait_rv", rsp_valid, 0);
      chk("wait_rdy", {req0_ready, req1_ready}, 0);
      chk("wait_x", alu_x, ex);
      alu_done = (k == lat);
      alu_sum  = (k == lat) ? eres : 8'($urandom);
    end

    for (int s = 0; s <= stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      alu_done = 1'b0;
      alu_sum  = 8'($urandom);
      chk("resp_rv", rsp_valid, 1);
      chk("resp_id", rsp_id, win);
      chk("resp_data", rsp_data, edata);
      chk("resp_err", rsp_err, eerr);
      chk("resp_rdy", {req0_ready, req1_ready}, 0);
      chk("resp_op", alu_op, eop);
      chk("resp_y", alu_y, ey);
      rsp_ready = (s == stall);
    end
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_rv", rsp_valid, 0);
    chk("post_start", alu_start, 0);
  endtask

  initial begin
    bit v0, v1;
    int r, lat;
    #2;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single NAND request: ~(0x07 & 0x02) = 0xFD
    run_txn(1, 0, 3'd0, 8'h07, 8'h02, 3'd0, 8'h00, 8'h00, 3, 0, 0);
    chk("nand_data", rsp_data, 8'hFD);

    // contention with immediate consumer
    for (int i = 0; i < 4; i++)
      run_txn(1, 1, 3'($urandom), 8'($urandom), 8'($urandom),
                    3'($urandom), 8'($urandom), 8'($urandom), 1, 0, 0);

    // backpressure, timeout, then a normal request
    run_txn(1, 1, 3'd2, 8'h5A, 8'h0F, 3'd3, 8'hA5, 8'hFF, 2, 0, 5);
    run_txn(0, 1, 3'd1, 8'h11, 8'h22, 3'd4, 8'h33, 8'h44, 0, 0, 0);
    run_txn(1, 0, 3'd5, 8'hF0, 8'h20, 3'd0, 8'h00, 8'h00, 1, 0, 1);

    // done in ISSUE ignored; done coinciding with the watchdog wins
    run_txn(1, 0, 3'd6, 8'h10, 8'h01, 3'd0, 8'h00, 8'h00, 2, 1, 0);
    run_txn(0, 1, 3'd7, 8'h3C, 8'h00, 3'd0, 8'h00, 8'h00, TO, 1, 0);

    // reset in the middle of WAIT
    req0_valid = 1'b0; req1_valid = 1'b1; req1_op = 3'd2; req1_a = 8'h81; req1_b = 8'h18;
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    chk("mid_start", alu_start, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("arst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_grant = 1;
    alu_done = 1'b1; alu_sum = 8'h77;
    @(negedge clk);
    alu_done = 1'b0;
    chk("late_done_rv", rsp_valid, 0);
    chk("late_done_start", alu_start, 0);
    @(negedge clk);
    chk("late_done_rv2", rsp_valid, 0);
    run_txn(1, 1, 3'd0, 8'hFF, 8'hFF, 3'd1, 8'hC3, 8'h3C, 2, 0, 0);
    run_txn(0, 1, 3'd3, 8'h12, 8'h34, 3'd2, 8'h40, 8'h04, 4, 0, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 2);
      v0 = (r != 1);
      v1 = (r != 0);
      r = $urandom_range(0, 9);
      if (r == 0)      lat = 0;
      else if (r == 1) lat = TO;
      else             lat = $urandom_range(1, TO + 3);
      run_txn(v0, v1, 3'($urandom), 8'($urandom), 8'($urandom),
                      3'($urandom), 8'($urandom), 8'($urandom),
                      lat, 1'($urandom), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
